mem_writeback_stage: RTL and testbench
======================================

Name: mem_writeback_stage

Overview:
- Memory-access and writeback pipeline stage for the MIPS core.
- Captures ALU result, store data and write destination from execute.
- Runs loads/stores against data memory over a req/ack handshake and stalls upstream while an access is pending.
- Drives the register-file write port (enable, dest, data) that the decode stage consumes.

Parameters:
TIMEOUT, 16, cycles without mem_ack_in before an access is abandoned (legal range 2..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
alu_result_in  in  32  ALU result; memory address for loads and stores
store_data_in  in  32  rt value to be stored
reg_write_dest_in  in  5  destination register
ctrl_in  in  6  [0] mem_read, [1] mem_write, [2] wb_en, [4:3] size (00 byte, 01 half, 10 word), [5] load unsigned
stall_out  out  1  upstream must hold its registers; input capture is blocked
mem_req_out  out  1  data-memory request
mem_we_out  out  1  1 = store
mem_addr_out  out  32  word-aligned address ({addr[31:2], 2'b00})
mem_wdata_out  out  32  lane-replicated store data
mem_be_out  out  4  byte enables; bit i = byte lane i, little-endian
mem_ack_in  in  1  single-cycle completion strobe
mem_rdata_in  in  32  read word, valid when mem_ack_in = 1
reg_write_en_out  out  1  register-file write enable
reg_write_dest_out  out  5  register-file write address
reg_write_data_out  out  32  register-file write data
align_err_out  out  1  sticky misaligned-access flag
mem_err_out  out  1  sticky timeout flag

Behaviour:
- Stage register M holds addr, store data, dest and ctrl.
  - M loads the inputs on a clock edge when stall_out = 0.
  - Reset clears M to a bubble (all ctrl = 0).
- FSM states: IDLE, ACCESS. Reset state is IDLE.
- IDLE:
  - A valid mem op in M (mem_read or mem_write, aligned) moves to ACCESS on the next edge.
  - Misaligned ops are half with addr[0] = 1, or word with addr[1:0] != 0. For these: no request is issued, the register-file write is suppressed, align_err_out is set, and the op retires like a non-memory op.
  - Non-memory ops retire on the next edge: W gets en = wb_en, dest, data = addr.
  - mem_read and mem_write both set: treat as mem_read.
- ACCESS:
  - mem_req_out = 1; addr, we, wdata and be are held stable, all derived from M.
  - Timeout counter starts at 0 on entry and increments each cycle without ack.
  - mem_ack_in = 1: complete on that edge and return to IDLE.
  - Counter == TIMEOUT-1 with no ack: abandon the access. Return to IDLE, write is suppressed, mem_err_out is set, and an ack that arrives later is ignored.
- Entry into ACCESS (IDLE with a valid aligned mem op in M): stall_out = 1. This holds the next instruction upstream for the edge that moves the FSM to ACCESS; M is not overwritten on that edge.
- stall_out = (state == ACCESS) & ~mem_ack_in & ~(counter == TIMEOUT-1), OR'd with the entry condition above. stall_out is combinational.
  - On the completing edge, M therefore captures the next instruction (zero-bubble resume).
- Writeback register W drives reg_write_*_out with 1-cycle latency after retire. All three reset to 0.
- Loads:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Result is sign-extended unless ctrl[5] = 1, in which case it is zero-extended.
  - W.en = wb_en.
- Stores:
  - W.en = 0.
  - Byte: wdata = {4{data[7:0]}}, be = 4'b0001 << addr[1:0].
  - Half: wdata = {2{data[15:0]}}, be = addr[1] ? 1100 : 0011.
  - Word: be = 1111.
- mem_we_out, mem_addr_out, mem_wdata_out and mem_be_out are 0 whenever mem_req_out = 0.
- dest = 0 is passed through unchanged; the register file ignores writes to $0.
- Sticky flags clear only on reset.
- Reset mid-access: mem_req_out and stall_out drop immediately (asynchronously) and the FSM returns to IDLE.

Test Plan:
- ALU op: addr 0x1234, dest 5, wb_en -> one cycle later en = 1, dest = 5, data = 0x00001234; stall_out never asserts.
- lb at 0x1003, rdata 0x80FF_0011, ack on the 3rd ACCESS cycle -> stall_out high for 3 cycles (entry cycle + 2 ACCESS cycles); mem_addr_out = 0x1000; data = 0xFFFFFF80. With ctrl[5] = 1 -> 0x00000080.
- sh 0xABCD at 0x2002 -> be = 1100, wdata = 0xABCDABCD, we = 1; after ack, reg_write_en_out = 0.
- lw at 0x2001 -> mem_req_out stays 0, align_err_out = 1, no register write, next instruction captured without stall.
- lw, TIMEOUT = 16, no ack -> req held 16 cycles, then released; mem_err_out = 1, no write; a late ack is ignored.
- Reset asserted on the 2nd ACCESS cycle -> req, stall and all outputs go to 0 immediately; after release, an ALU op retires normally.

Source files
------------

// File: rtl/mem_writeback_stage_if.sv
// mem_writeback_stage_if: data-memory req/ack bus between the writeback stage and memory
interface mem_writeback_stage_if;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic [3:0]  mem_be_out;
    logic        mem_ack_in;
    logic [31:0] mem_rdata_in;
    modport master (
        output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_be_out,
        input  mem_ack_in, mem_rdata_in
    );
    modport slave (
        input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_be_out,
        output mem_ack_in, mem_rdata_in
    );
endinterface

// File: rtl/mem_writeback_stage.sv
// mem_writeback_stage: MIPS memory-access and register writeback stage
module mem_writeback_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  alu_result_in,
    input  logic [31:0]                  store_data_in,
    input  logic [4:0]                   reg_write_dest_in,
    input  logic [5:0]                   ctrl_in,
    output logic                         stall_out,
    mem_writeback_stage_if.master        mem,
    output logic                         reg_write_en_out,
    output logic [4:0]                   reg_write_dest_out,
    output logic [31:0]                  reg_write_data_out,
    output logic                         align_err_out,
    output logic                         mem_err_out
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] m_addr, m_data;
    logic [4:0]  m_dest;
    logic [5:0]  m_ctrl;
    logic        is_read, mem_op, misalign, entry, last, in_access, ack;
    logic [1:0]  size;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data, wdata_raw;
    logic [3:0]  be_raw;
    assign is_read   = m_ctrl[0];
    assign mem_op    = m_ctrl[0] | m_ctrl[1];
    assign size      = m_ctrl[4:3];
    assign misalign  = mem_op & ((size == 2'b01 & m_addr[0]) | (size[1] & |m_addr[1:0]));
    assign in_access = state == ACCESS;
    assign entry     = state == IDLE & mem_op & ~misalign;
    assign last      = cnt == 8'(TIMEOUT - 1);
    assign ack       = mem.mem_ack_in;
    // Entry holds the next instruction for one edge; the completing or abandoning edge releases it.
    assign stall_out = entry | (in_access & ~ack & ~last);
    assign ld_byte   = mem.mem_rdata_in[{m_addr[1:0], 3'b000} +: 8];
    assign ld_half   = m_addr[1] ? mem.mem_rdata_in[31:16] : mem.mem_rdata_in[15:0];
    assign ld_data   = size == 2'b00 ? {{24{~m_ctrl[5] & ld_byte[7]}}, ld_byte}
                     : size == 2'b01 ? {{16{~m_ctrl[5] & ld_half[15]}}, ld_half}
                     : mem.mem_rdata_in;
    assign be_raw    = size == 2'b00 ? 4'b0001 << m_addr[1:0]
                     : size == 2'b01 ? (m_addr[1] ? 4'b1100 : 4'b0011)
                     : 4'b1111;
    assign wdata_raw = size == 2'b00 ? {4{m_data[7:0]}}
                     : size == 2'b01 ? {2{m_data[15:0]}}
                     : m_data;
    assign mem.mem_req_out   = in_access;
    assign mem.mem_we_out    = in_access & ~is_read;
    assign mem.mem_addr_out  = in_access ? {m_addr[31:2], 2'b00} : 32'h0;
    assign mem.mem_wdata_out = in_access ? wdata_raw : 32'h0;
    assign mem.mem_be_out    = in_access ? be_raw : 4'h0;
    // Stage register M: captures execute results whenever upstream is not stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_addr <= '0;
            m_data <= '0;
            m_dest <= '0;
            m_ctrl <= '0;
        end else if (!stall_out) begin
            m_addr <= alu_result_in;
            m_data <= store_data_in;
            m_dest <= reg_write_dest_in;
            m_ctrl <= ctrl_in;
        end
    end
    // Access FSM, timeout counter, writeback register W and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            reg_write_en_out   <= 1'b0;
            reg_write_dest_out <= '0;
            reg_write_data_out <= '0;
            align_err_out      <= 1'b0;
            mem_err_out        <= 1'b0;
        end else begin
            state              <= (entry | (in_access & ~ack & ~last)) ? ACCESS : IDLE;
            cnt                <= in_access ? cnt + 8'd1 : 8'd0;
            reg_write_en_out   <= in_access ? ack & is_read & m_ctrl[2] : ~mem_op & m_ctrl[2];
            reg_write_dest_out <= m_dest;
            reg_write_data_out <= in_access ? ld_data : m_addr;
            align_err_out      <= align_err_out | (state == IDLE & misalign);
            mem_err_out        <= mem_err_out | (in_access & ~ack & last);
        end
    end
endmodule

// File: tb/tb_mem_writeback_stage.sv
// tb_mem_writeback_stage: directed vector and sequence checks for mem_writeback_stage
module tb_mem_writeback_stage;
    logic        clk = 0, reset = 1;
    logic [31:0] alu_result_in = 0, store_data_in = 0;
    logic [4:0]  reg_write_dest_in = 0;
    logic [5:0]  ctrl_in = 0;
    logic        stall_out, reg_write_en_out, align_err_out, mem_err_out;
    logic [4:0]  reg_write_dest_out;
    logic [31:0] reg_write_data_out;
    int          checks = 0, failures = 0;
    mem_writeback_stage_if bus();
    mem_writeback_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .alu_result_in(alu_result_in), .store_data_in(store_data_in),
        .reg_write_dest_in(reg_write_dest_in), .ctrl_in(ctrl_in), .stall_out(stall_out), .mem(bus),
        .reg_write_en_out(reg_write_en_out), .reg_write_dest_out(reg_write_dest_out),
        .reg_write_data_out(reg_write_data_out), .align_err_out(align_err_out), .mem_err_out(mem_err_out)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] addr;
        logic [4:0]  dest;
        logic [5:0]  ctrl;
        logic        en;
        logic [31:0] data;
        logic        align;
    } vec_t;
    vec_t vecs[6];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r, input logic [5:0] c);
        alu_result_in = a;
        store_data_in = d;
        reg_write_dest_in = r;
        ctrl_in = c;
    endtask
    task automatic mem_seq(input string name, input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                           input logic [5:0] c, input int k, input logic [31:0] rd, input logic we,
                           input logic [3:0] be, input logic [31:0] wd, input logic en, input logic [31:0] data);
        int stalls;
        drive(a, d, r, c);
        step();
        drive(32'h77, 0, 5'd3, 6'b000100);
        @(negedge clk);
        chk({name, " entry stall"}, stall_out, 1);
        chk({name, " entry req"}, bus.mem_req_out, 0);
        stalls = 1;
        for (int i = 1; i <= k; i++) begin
            step();
            if (i == k) begin
                bus.mem_ack_in = 1;
                bus.mem_rdata_in = rd;
            end
            @(negedge clk);
            chk({name, " req"}, bus.mem_req_out, 1);
            chk({name, " we"}, bus.mem_we_out, we);
            chk({name, " addr"}, bus.mem_addr_out, {a[31:2], 2'b00});
            chk({name, " be"}, bus.mem_be_out, be);
            chk({name, " wdata"}, bus.mem_wdata_out, wd);
            if (stall_out) stalls++;
        end
        step();
        bus.mem_ack_in = 0;
        bus.mem_rdata_in = 0;
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk({name, " stall cycles"}, stalls, k);
        chk({name, " req released"}, bus.mem_req_out, 0);
        chk({name, " wb en"}, reg_write_en_out, en);
        if (en) begin
            chk({name, " wb dest"}, reg_write_dest_out, r);
            chk({name, " wb data"}, reg_write_data_out, data);
        end
        step();
        @(negedge clk);
        chk({name, " follower en"}, reg_write_en_out, 1);
        chk({name, " follower dest"}, reg_write_dest_out, 3);
        chk({name, " follower data"}, reg_write_data_out, 32'h77);
    endtask
    initial begin
        int reqs, stalls, wens;
        vecs[0] = '{32'h0000_1234, 5'd5,  6'b000100, 1, 32'h0000_1234, 0};
        vecs[1] = '{32'hDEAD_BEEF, 5'd7,  6'b000000, 0, 32'h0,         0};
        vecs[2] = '{32'h0000_0055, 5'd0,  6'b000100, 1, 32'h0000_0055, 0};
        vecs[3] = '{32'h0000_2001, 5'd9,  6'b010101, 0, 32'h0,         1};
        vecs[4] = '{32'h0000_0003, 5'd10, 6'b001010, 0, 32'h0,         1};
        vecs[5] = '{32'hCAFE_F00D, 5'd31, 6'b000100, 1, 32'hCAFE_F00D, 1};
        bus.mem_ack_in = 0;
        bus.mem_rdata_in = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall", stall_out, 0);
        chk("reset req", bus.mem_req_out, 0);
        chk("reset wb en", reg_write_en_out, 0);
        chk("reset wb data", reg_write_data_out, 0);
        chk("reset align", align_err_out, 0);
        chk("reset memerr", mem_err_out, 0);
        reset = 0;
        for (int v = 0; v < 6; v++) begin
            drive(vecs[v].addr, 32'h1111_2222, vecs[v].dest, vecs[v].ctrl);
            step();
            drive(0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("vec%0d stall", v), stall_out, 0);
            chk($sformatf("vec%0d req", v), bus.mem_req_out, 0);
            step();
            @(negedge clk);
            chk($sformatf("vec%0d en", v), reg_write_en_out, vecs[v].en);
            if (vecs[v].en) begin
                chk($sformatf("vec%0d dest", v), reg_write_dest_out, vecs[v].dest);
                chk($sformatf("vec%0d data", v), reg_write_data_out, vecs[v].data);
            end
            chk($sformatf("vec%0d align", v), align_err_out, vecs[v].align);
        end
        mem_seq("lb",  32'h1003, 0, 5'd8,  6'b000101, 3, 32'h80FF_0011, 0, 4'b1000, 0, 1, 32'hFFFF_FF80);
        mem_seq("lbu", 32'h1003, 0, 5'd8,  6'b100101, 1, 32'h80FF_0011, 0, 4'b1000, 0, 1, 32'h0000_0080);
        mem_seq("lh",  32'h2002, 0, 5'd12, 6'b001101, 2, 32'h8001_1234, 0, 4'b1100, 0, 1, 32'hFFFF_8001);
        mem_seq("sh",  32'h2002, 32'h0000_ABCD, 5'd13, 6'b001110, 2, 0, 1, 4'b1100, 32'hABCD_ABCD, 0, 0);
        mem_seq("sb",  32'h2001, 32'h0000_005A, 5'd14, 6'b000010, 1, 0, 1, 4'b0010, 32'h5A5A_5A5A, 0, 0);
        drive(32'h4000, 0, 5'd6, 6'b010101);
        step();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("timeout entry stall", stall_out, 1);
        chk("timeout memerr before", mem_err_out, 0);
        reqs = 0;
        stalls = 1;
        wens = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            if (bus.mem_req_out) reqs++;
            if (stall_out) stalls++;
            if (reg_write_en_out) wens++;
        end
        chk("timeout req cycles", reqs, 16);
        chk("timeout stall cycles", stalls, 16);
        chk("timeout wb writes", wens, 0);
        chk("timeout memerr", mem_err_out, 1);
        bus.mem_ack_in = 1;
        bus.mem_rdata_in = 32'hFFFF_FFFF;
        step();
        bus.mem_ack_in = 0;
        @(negedge clk);
        chk("late ack req", bus.mem_req_out, 0);
        step();
        @(negedge clk);
        chk("late ack wb en", reg_write_en_out, 0);
        drive(32'h5000, 0, 5'd2, 6'b010101);
        step();
        drive(0, 0, 0, 0);
        step();
        step();
        @(negedge clk);
        chk("pre-reset req", bus.mem_req_out, 1);
        #2;
        reset = 1;
        #1;
        chk("async reset req", bus.mem_req_out, 0);
        chk("async reset stall", stall_out, 0);
        chk("async reset addr", bus.mem_addr_out, 0);
        chk("async reset align", align_err_out, 0);
        chk("async reset memerr", mem_err_out, 0);
        chk("async reset wb en", reg_write_en_out, 0);
        drive(32'h99, 0, 5'd4, 6'b000100);
        @(negedge clk);
        reset = 0;
        step();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("post-reset stall", stall_out, 0);
        step();
        @(negedge clk);
        chk("post-reset en", reg_write_en_out, 1);
        chk("post-reset dest", reg_write_dest_out, 4);
        chk("post-reset data", reg_write_data_out, 32'h99);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
